// File: rtl/pixel_pipe_scheduler.sv
// rtl/pixel_pipe_scheduler.sv - frame sequencer with credit-based admission into the fixed-latency pixel pipeline
module pixel_pipe_scheduler #(
    parameter int LATENCY   = 3,
    parameter int BUF_DEPTH = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pixels,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             issue,
    input  logic             pipe_valid_out,
    input  logic             buf_pop,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] issued_count,
    output logic             protocol_err
);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    if (LATENCY < 1) begin : g_bad_latency
        $error("pixel_pipe_scheduler: LATENCY must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    credits;
    logic [CNT_W-1:0] retired;
    logic [CNT_W-1:0] target;
    logic             credits_full;
    logic             counting;
    logic [CNT_W-1:0] retired_nxt;

    assign credits_full = (credits == CW'(BUF_DEPTH));
    assign counting     = (state == RUN) || (state == DRAIN);
    assign retired_nxt  = retired + CNT_W'(pipe_valid_out);

    assign in_ready = (state == RUN) && (credits != '0) && (issued_count < target);
    assign issue    = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            credits      <= CW'(BUF_DEPTH);
            retired      <= '0;
            target       <= '0;
            issued_count <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // A pop with every credit home means the buffer was already empty.
            if (issue && !buf_pop)
                credits <= credits - CW'(1);
            else if (buf_pop && !issue && !credits_full)
                credits <= credits + CW'(1);

            if ((buf_pop && credits_full) || (pipe_valid_out && !counting))
                protocol_err <= 1'b1;

            if (pipe_valid_out && counting)
                retired <= retired_nxt;

            case (state)
                IDLE: begin
                    if (start) begin
                        target       <= num_pixels;
                        issued_count <= '0;
                        retired      <= '0;
                        busy         <= 1'b1;
                        if (num_pixels == '0) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        issued_count <= issued_count + CNT_W'(1);
                        if (issued_count + CNT_W'(1) == target)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (retired_nxt == target) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_pipe_scheduler.sv
// tb/tb_pixel_pipe_scheduler.sv - bench for pixel_pipe_scheduler at buffer depths 8 and 4
module tb_pixel_pipe_scheduler;
    localparam int CNT_W = 16;
    localparam int LAT   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic buf_pop = 1'b0;
    logic pipe_en = 1'b0;
    logic [CNT_W-1:0] num_pixels = '0;

    logic             in_ready_s [2];
    logic             issue_s    [2];
    logic             busy_s     [2];
    logic             fd_s       [2];
    logic             err_s      [2];
    logic             pvo_s      [2];
    logic [CNT_W-1:0] cnt_s      [2];
    logic [LAT-1:0]   pipe       [2];
    int               dcred      [2];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pixel_pipe_scheduler #(.LATENCY(LAT), .BUF_DEPTH(8), .CNT_W(CNT_W)) dut8 (
        .clk(clk), .rst(rst), .start(start), .num_pixels(num_pixels),
        .in_valid(in_valid), .in_ready(in_ready_s[0]), .issue(issue_s[0]),
        .pipe_valid_out(pvo_s[0]), .buf_pop(buf_pop), .busy(busy_s[0]),
        .frame_done(fd_s[0]), .issued_count(cnt_s[0]), .protocol_err(err_s[0])
    );

    pixel_pipe_scheduler #(.LATENCY(LAT), .BUF_DEPTH(4), .CNT_W(CNT_W)) dut4 (
        .clk(clk), .rst(rst), .start(start), .num_pixels(num_pixels),
        .in_valid(in_valid), .in_ready(in_ready_s[1]), .issue(issue_s[1]),
        .pipe_valid_out(pvo_s[1]), .buf_pop(buf_pop), .busy(busy_s[1]),
        .frame_done(fd_s[1]), .issued_count(cnt_s[1]), .protocol_err(err_s[1])
    );

    assign dcred[0] = int'(dut8.credits);
    assign dcred[1] = int'(dut4.credits);
    assign pvo_s[0] = pipe[0][LAT-1];
    assign pvo_s[1] = pipe[1][LAT-1];

    // Stand-in for the pipeline's valid delay chain.
    always @(posedge clk)
        for (int k = 0; k < 2; k++)
            pipe[k] <= rst ? '0 : {pipe[k][LAT-2:0], issue_s[k] & pipe_en};

    // Frame model: a frame is active from accepted start until every pixel has been issued and retired.
    int md[2] = '{8, 4};
    bit m_active[2] = '{0, 0};
    bit m_done[2]   = '{0, 0};
    bit m_err[2]    = '{0, 0};
    int m_iss[2]    = '{0, 0};
    int m_ret[2]    = '{0, 0};
    int m_tgt[2]    = '{0, 0};
    int m_cred[2]   = '{8, 4};
    bit t_iss, t_pv;

    function automatic bit exp_ready(int k);
        return m_active[k] && (m_iss[k] < m_tgt[k]) && (m_cred[k] > 0);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_active[k] = 0; m_done[k] = 0; m_err[k] = 0;
                m_iss[k] = 0; m_ret[k] = 0; m_tgt[k] = 0; m_cred[k] = md[k];
            end else begin
                t_iss = in_valid && exp_ready(k);
                t_pv  = pvo_s[k];
                if (buf_pop && m_cred[k] == md[k]) m_err[k] = 1;
                if (t_pv && !m_active[k]) m_err[k] = 1;
                if (t_iss && !buf_pop) m_cred[k] = m_cred[k] - 1;
                else if (buf_pop && !t_iss && m_cred[k] < md[k]) m_cred[k] = m_cred[k] + 1;
                if (m_done[k]) begin
                    m_done[k] = 0;
                end else if (m_active[k]) begin
                    if (t_iss) m_iss[k] = m_iss[k] + 1;
                    if (t_pv) m_ret[k] = m_ret[k] + 1;
                    if (m_iss[k] == m_tgt[k] && m_ret[k] == m_tgt[k]) begin
                        m_active[k] = 0;
                        m_done[k] = 1;
                    end
                end else if (start) begin
                    m_tgt[k] = int'(num_pixels);
                    m_iss[k] = 0;
                    m_ret[k] = 0;
                    if (num_pixels == '0) m_done[k] = 1;
                    else m_active[k] = 1;
                end
            end
        end
    end

    task automatic check(input string nm, input int k, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", nm, k, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check("in_ready", k, int'(in_ready_s[k]), int'(exp_ready(k)));
            check("issue", k, int'(issue_s[k]), int'(in_valid && exp_ready(k)));
            check("busy", k, int'(busy_s[k]), int'(m_active[k] || m_done[k]));
            check("frame_done", k, int'(fd_s[k]), int'(m_done[k]));
            check("issued_count", k, int'(cnt_s[k]), m_iss[k]);
            check("protocol_err", k, int'(err_s[k]), int'(m_err[k]));
            check("credits", k, dcred[k], m_cred[k]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; start = 0; in_valid = 0; buf_pop = 0; num_pixels = '0;
        step();
        step();
        rst = 0;
    endtask

    initial begin
        int n_is, n_pv, n_fd, last_pv, fd_c;

        // reset with random inputs, then a pop with all credits home
        repeat (2) begin
            in_valid = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            buf_pop = 1'($urandom_range(0, 1));
            num_pixels = CNT_W'($urandom);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            check("t1_issue", k, int'(issue_s[k]), 0);
            check("t1_in_ready", k, int'(in_ready_s[k]), 0);
            check("t1_busy", k, int'(busy_s[k]), 0);
            check("t1_frame_done", k, int'(fd_s[k]), 0);
            check("t1_count", k, int'(cnt_s[k]), 0);
            check("t1_err", k, int'(err_s[k]), 0);
        end
        check("t1_credits", 0, dcred[0], 8);
        check("t1_credits", 1, dcred[1], 4);
        rst = 0; start = 0; in_valid = 0; num_pixels = '0; buf_pop = 1;
        step();
        check("t1_err_pop", 0, int'(err_s[0]), 1);
        check("t1_err_pop", 1, int'(err_s[1]), 1);
        buf_pop = 0;

        // credit stall at depth 4
        do_reset();
        start = 1; num_pixels = 5; in_valid = 1;
        step();
        start = 0;
        for (int i = 0; i < 4; i++) begin
            check("t2_issue", 1, int'(issue_s[1]), 1);
            step();
        end
        check("t2_stall_ready", 1, int'(in_ready_s[1]), 0);
        check("t2_stall_count", 1, int'(cnt_s[1]), 4);
        buf_pop = 1;
        step();
        buf_pop = 0;
        check("t2_fifth_issue", 1, int'(issue_s[1]), 1);
        step();
        check("t2_drain_count", 1, int'(cnt_s[1]), 5);
        check("t2_drain_ready", 1, int'(in_ready_s[1]), 0);
        check("t2_drain_busy", 1, int'(busy_s[1]), 1);
        in_valid = 0;

        // full frame through the delay chain
        do_reset();
        pipe_en = 1; start = 1; num_pixels = 5; in_valid = 1;
        step();
        start = 0;
        n_is = 0; n_pv = 0; n_fd = 0; last_pv = -1; fd_c = -1;
        for (int c = 1; c <= 20; c++) begin
            if (issue_s[0]) n_is++;
            if (pvo_s[0]) begin n_pv++; last_pv = c; end
            if (fd_s[0]) begin n_fd++; fd_c = c; end
            step();
        end
        check("t3_issues", 0, n_is, 5);
        check("t3_retires", 0, n_pv, 5);
        check("t3_done_pulses", 0, n_fd, 1);
        check("t3_last_pvo_cycle", 0, last_pv, 8);
        check("t3_done_cycle", 0, fd_c, 9);
        check("t3_busy", 0, int'(busy_s[0]), 0);
        check("t3_count", 0, int'(cnt_s[0]), 5);
        check("t3_credits_kept", 0, dcred[0], 3);
        in_valid = 0;

        // empty frame
        do_reset();
        start = 1; num_pixels = 0; in_valid = 1;
        step();
        start = 0;
        check("t4_done", 0, int'(fd_s[0]), 1);
        check("t4_issue", 0, int'(issue_s[0]), 0);
        step();
        check("t4_busy", 0, int'(busy_s[0]), 0);
        check("t4_done_off", 0, int'(fd_s[0]), 0);
        in_valid = 0;

        // issue and pop together at one credit
        do_reset();
        pipe_en = 0; start = 1; num_pixels = 20; in_valid = 1;
        step();
        start = 0;
        repeat (7) step();
        check("t5_one_credit", 0, dcred[0], 1);
        check("t5_issue", 0, int'(issue_s[0]), 1);
        buf_pop = 1;
        step();
        buf_pop = 0;
        check("t5_credit_same", 0, dcred[0], 1);
        check("t5_count", 0, int'(cnt_s[0]), 8);

        // start during DRAIN is ignored
        do_reset();
        pipe_en = 1; start = 1; num_pixels = 3; in_valid = 1;
        step();
        start = 0;
        repeat (3) step();
        check("t5_drain_ready", 0, int'(in_ready_s[0]), 0);
        start = 1; num_pixels = 7;
        step();
        start = 0;
        check("t5_target_kept", 0, int'(dut8.target), 3);
        n_fd = 0;
        for (int c = 0; c < 10; c++) begin
            if (fd_s[0]) n_fd++;
            step();
        end
        check("t5_done_seen", 0, n_fd, 1);
        check("t5_drain_count", 0, int'(cnt_s[0]), 3);
        in_valid = 0;

        // reset mid-frame, then a normal frame
        do_reset();
        pipe_en = 1; start = 1; num_pixels = 10; in_valid = 1;
        step();
        start = 0;
        repeat (3) step();
        check("t6_count_before", 0, int'(cnt_s[0]), 3);
        rst = 1;
        step();
        check("t6_busy", 0, int'(busy_s[0]), 0);
        check("t6_credits", 0, dcred[0], 8);
        rst = 0; in_valid = 0;
        n_fd = 0;
        repeat (5) begin
            if (fd_s[0]) n_fd++;
            step();
        end
        check("t6_no_done", 0, n_fd, 0);
        start = 1; num_pixels = 2; in_valid = 1;
        step();
        start = 0;
        n_fd = 0; n_is = 0;
        for (int c = 0; c < 15; c++) begin
            if (issue_s[0]) n_is++;
            if (fd_s[0]) n_fd++;
            step();
        end
        check("t6_done", 0, n_fd, 1);
        check("t6_issues", 0, n_is, 2);
        check("t6_count", 0, int'(cnt_s[0]), 2);
        check("t6_idle", 0, int'(busy_s[0]), 0);
        in_valid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
